// File: rtl/main_mem_line.sv
// ---------------------------------------------------------------------------
// main_mem_line
//
// Line-granularity main-memory model with a fixed, parameterised access
// latency. It serves refill reads and write-backs from the data cache. One
// transaction is in flight at a time. The requester's stall resolves on the
// single-cycle gnt pulse. Completed reads and writes are counted with
// saturation so that miss-rate statistics can be derived from them.
//
// Parameters
//   LINE_ADDR_LEN  log2 of 32-bit words per line
//   MEM_LINE_BITS  log2 of lines stored
//   LATENCY        cycles from request acceptance to gnt (legal 2..1023)
//
// Ports
//   clk             clock, all state changes on the rising edge
//   rst             asynchronous, active-high reset
//   addr            byte address; the line index is taken from
//                   addr[LINE_ADDR_LEN+2 +: MEM_LINE_BITS]
//   rd_req          refill request, held until gnt
//   wr_req          write-back request, held until gnt; wins over rd_req
//   wr_line         line to write, word 0 in bits [31:0]
//   rd_line         last line read, valid from its gnt until the next read gnt
//   gnt             one-cycle completion pulse
//   busy            a transaction is in progress
//   rd_count        completed reads, saturating
//   wr_count        completed writes, saturating
//   debug_addr      byte address of a word to observe
//   debug_out_data  committed word at debug_addr, one cycle later
// ---------------------------------------------------------------------------
module main_mem_line #(
  parameter int unsigned LINE_ADDR_LEN = 3,
  parameter int unsigned MEM_LINE_BITS = 7,
  parameter int unsigned LATENCY       = 50
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [31:0]                         addr,
  input  logic                                rd_req,
  input  logic                                wr_req,
  input  logic [32*(2**LINE_ADDR_LEN)-1:0]    wr_line,
  output logic [32*(2**LINE_ADDR_LEN)-1:0]    rd_line,
  output logic                                gnt,
  output logic                                busy,
  output logic [31:0]                         rd_count,
  output logic [31:0]                         wr_count,
  input  logic [31:0]                         debug_addr,
  output logic [31:0]                         debug_out_data
);

  localparam int unsigned WORDS  = 2 ** LINE_ADDR_LEN;
  localparam int unsigned LINE_W = 32 * WORDS;
  localparam int unsigned DEPTH  = 2 ** MEM_LINE_BITS;
  localparam int unsigned CNT_W  = 10;
  // Address bit just above the line index; everything from here up is ignored.
  localparam int unsigned ADDR_TOP = MEM_LINE_BITS + LINE_ADDR_LEN + 2;

  // The WAIT phase lasts LATENCY-1 edges including the one that enters DONE,
  // and DONE itself is the LATENCY-th cycle. Starting the down-counter at
  // LATENCY-2 makes gnt land on exactly that cycle.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 2);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DONE
  } state_t;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_t                     r_state;
  logic [CNT_W-1:0]           r_cnt;
  logic                       r_is_wr;
  logic [MEM_LINE_BITS-1:0]   r_line_idx;
  logic [LINE_W-1:0]          r_wr_line;
  logic                       r_gnt;
  logic                       r_busy;
  logic [LINE_W-1:0]          r_rd_line;
  logic [31:0]                r_rd_count;
  logic [31:0]                r_wr_count;
  logic [31:0]                r_debug_data;

  // NOTE: the storage array has no reset. Clearing a RAM from rst is not
  // something real memories can do, and a reset in the middle of a write-back
  // must leave the old contents intact. The declaration initialiser gives the
  // time-zero (simulation / FPGA bitstream) contents of all zeros.
  logic [LINE_W-1:0]          r_mem [DEPTH] = '{default: '0};

  // -------------------------------------------------------------------------
  // Address decode
  // -------------------------------------------------------------------------
  logic [MEM_LINE_BITS-1:0]   w_req_line;
  logic [MEM_LINE_BITS-1:0]   w_dbg_line;
  logic [LINE_ADDR_LEN-1:0]   w_dbg_word;
  logic [LINE_W-1:0]          w_dbg_line_data;
  logic                       w_commit;
  logic                       w_unused;

  assign w_req_line      = addr[LINE_ADDR_LEN+2 +: MEM_LINE_BITS];
  assign w_dbg_line      = debug_addr[LINE_ADDR_LEN+2 +: MEM_LINE_BITS];
  assign w_dbg_word      = debug_addr[2 +: LINE_ADDR_LEN];
  assign w_dbg_line_data = r_mem[w_dbg_line];

  // A write-back lands in the array on the edge that leaves DONE. Because the
  // FSM is held in IDLE by reset, an aborted write never reaches this point.
  assign w_commit = (r_state == ST_DONE) && r_is_wr;

  // Byte-offset and above-array address bits are deliberately ignored, which
  // is what makes addresses a multiple of the array size apart alias.
  assign w_unused = ^{addr[31:ADDR_TOP], addr[LINE_ADDR_LEN+1:0],
                      debug_addr[31:ADDR_TOP], debug_addr[1:0]};

  // -------------------------------------------------------------------------
  // Transaction FSM with registered outputs
  // -------------------------------------------------------------------------
  // NOTE: every register below is assigned with <= so that all of them sample
  // the pre-edge values. For example, rd_line reads the array before a write
  // committed on the same edge could be seen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_is_wr    <= 1'b0;
      r_line_idx <= '0;
      r_wr_line  <= '0;
      r_gnt      <= 1'b0;
      r_busy     <= 1'b0;
      r_rd_line  <= '0;
      r_rd_count <= '0;
      r_wr_count <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (rd_req || wr_req) begin
            // Capture everything now. The requester may change addr and
            // wr_line afterwards without affecting this transaction.
            r_line_idx <= w_req_line;
            r_is_wr    <= wr_req;
            r_wr_line  <= wr_line;
            r_cnt      <= CNT_LOAD;
            r_busy     <= 1'b1;
            r_state    <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (r_cnt == '0) begin
            r_state <= ST_DONE;
            r_gnt   <= 1'b1;
            // The read data is registered on the way into DONE, so it is
            // already stable while gnt is high.
            if (!r_is_wr) begin
              r_rd_line <= r_mem[r_line_idx];
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end

        ST_DONE: begin
          r_gnt   <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
          // The counters saturate instead of wrapping, so the statistics
          // never fall back to small values.
          if (r_is_wr) begin
            if (r_wr_count != '1) begin
              r_wr_count <= r_wr_count + 32'd1;
            end
          end else begin
            if (r_rd_count != '1) begin
              r_rd_count <= r_rd_count + 32'd1;
            end
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_gnt   <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Storage write port
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_commit) begin
      r_mem[r_line_idx] <= r_wr_line;
    end
  end

  // -------------------------------------------------------------------------
  // Debug word read. This is a registered read of the committed contents, so
  // a write-back becomes visible one edge after it commits.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_debug_data <= '0;
    end else begin
      r_debug_data <= w_dbg_line_data[w_dbg_word*32 +: 32];
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign rd_line        = r_rd_line;
  assign gnt            = r_gnt;
  assign busy           = r_busy;
  assign rd_count       = r_rd_count;
  assign wr_count       = r_wr_count;
  assign debug_out_data = r_debug_data;

endmodule

// File: tb/tb_main_mem_line.sv
// ---------------------------------------------------------------------------
// tb_main_mem_line
//
// Directed bench for main_mem_line with the default geometry: 8 words per
// line, 128 lines, LATENCY = 50. Inputs change on the falling edge and outputs
// are sampled on the falling edge, half a cycle away from the active edge.
// ---------------------------------------------------------------------------
module tb_main_mem_line;

  localparam int LAT = 50;

  logic         clk;
  logic         rst;
  logic [31:0]  addr;
  logic         rd_req;
  logic         wr_req;
  logic [255:0] wr_line;
  logic [255:0] rd_line;
  logic         gnt;
  logic         busy;
  logic [31:0]  rd_count;
  logic [31:0]  wr_count;
  logic [31:0]  debug_addr;
  logic [31:0]  debug_out_data;

  int n_cmp;
  int n_fail;
  int exp_rd;
  int exp_wr;
  int cyc;
  int gnt_seen;

  main_mem_line #(
    .LINE_ADDR_LEN (3),
    .MEM_LINE_BITS (7),
    .LATENCY       (LAT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .addr           (addr),
    .rd_req         (rd_req),
    .wr_req         (wr_req),
    .wr_line        (wr_line),
    .rd_line        (rd_line),
    .gnt            (gnt),
    .busy           (busy),
    .rd_count       (rd_count),
    .wr_count       (wr_count),
    .debug_addr     (debug_addr),
    .debug_out_data (debug_out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] obs,
                       input logic [255:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_rd_count"}, 256'(rd_count), 256'(exp_rd));
    check({tag, "_wr_count"}, 256'(wr_count), 256'(exp_wr));
  endtask

  // Counts falling edges until gnt is seen high, starting from 'start'.
  // Called one falling edge before the accepting rising edge, a result of LAT
  // means gnt sat between edges t0+LAT-1 and t0+LAT. The loop is bounded, so
  // a missing gnt shows up as a wrong cycle count.
  task automatic wait_gnt(input int start, output int cycles);
    cycles = start;
    do begin
      @(negedge clk);
      cycles++;
    end while (!gnt && cycles < 1000);
  endtask

  function automatic logic [255:0] make_line(input logic [31:0] base);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) begin
      l[i*32 +: 32] = base + 32'(i);
    end
    return l;
  endfunction

  initial begin
    n_cmp      = 0;
    n_fail     = 0;
    exp_rd     = 0;
    exp_wr     = 0;
    rst        = 1'b1;
    addr       = '0;
    rd_req     = 1'b0;
    wr_req     = 1'b0;
    wr_line    = '0;
    debug_addr = '0;

    // ---- Reset state -------------------------------------------------------
    repeat (3) @(negedge clk);
    check("rst_gnt",     256'(gnt), 256'(0));
    check("rst_busy",    256'(busy), 256'(0));
    check("rst_rd_line", rd_line, '0);
    check("rst_debug",   256'(debug_out_data), 256'(0));
    check_counts("rst");
    rst = 1'b0;

    // ---- Read of an unwritten line: 50-cycle latency, zero data -------------
    @(negedge clk);
    addr   = 32'h40;
    rd_req = 1'b1;
    @(negedge clk);
    check("t1_busy_after_accept", 256'(busy), 256'(1));
    check("t1_gnt_early",         256'(gnt), 256'(0));
    wait_gnt(1, cyc);
    check("t1_latency", 256'(cyc), 256'(LAT));
    check("t1_rd_line", rd_line, '0);
    check("t1_busy_in_done", 256'(busy), 256'(1));
    rd_req = 1'b0;
    exp_rd++;
    @(negedge clk);
    check("t1_gnt_one_cycle", 256'(gnt), 256'(0));
    check("t1_busy_idle",     256'(busy), 256'(0));
    check_counts("t1");

    // ---- Write 0..7 to 0x40 with inputs scrambled after accept, then read ----
    addr    = 32'h40;
    wr_line = make_line(32'h0);
    wr_req  = 1'b1;
    @(negedge clk);
    addr    = 32'hC0;
    wr_line = '1;
    wait_gnt(1, cyc);
    check("t2_wr_latency",  256'(cyc), 256'(LAT));
    check("t2_rdline_hold", rd_line, '0);
    wr_req = 1'b0;
    rd_req = 1'b1;
    addr   = 32'h40;
    exp_wr++;
    wait_gnt(0, cyc);
    check("t2_gnt_gap", 256'(cyc), 256'(LAT + 1));
    check("t2_rd_line", rd_line, make_line(32'h0));
    rd_req = 1'b0;
    exp_rd++;
    @(negedge clk);
    check_counts("t2");

    // ---- Simultaneous rd_req and wr_req: write is served first ---------------
    addr    = 32'h80;
    wr_line = {8{32'hA5A5_A5A5}};
    rd_req  = 1'b1;
    wr_req  = 1'b1;
    wait_gnt(0, cyc);
    check("t3_wr_latency", 256'(cyc), 256'(LAT));
    check("t3_rdline_old", rd_line, make_line(32'h0));
    wr_req = 1'b0;
    exp_wr++;
    @(negedge clk);
    check("t3_idle_gap_busy", 256'(busy), 256'(0));
    check_counts("t3_after_wr");
    wait_gnt(1, cyc);
    check("t3_rd_gap",  256'(cyc), 256'(LAT + 1));
    check("t3_rd_line", rd_line, {8{32'hA5A5_A5A5}});
    rd_req = 1'b0;
    exp_rd++;
    @(negedge clk);
    check_counts("t3");

    // ---- Reset 10 cycles into a write to 0xC0: no gnt, no commit -------------
    addr    = 32'hC0;
    wr_line = make_line(32'hDEAD_0000);
    wr_req  = 1'b1;
    repeat (10) @(negedge clk);
    check("t4_busy_before_rst", 256'(busy), 256'(1));
    rst    = 1'b1;
    wr_req = 1'b0;
    #1;
    check("t4_busy_rst",    256'(busy), 256'(0));
    check("t4_gnt_rst",     256'(gnt), 256'(0));
    check("t4_rd_line_rst", rd_line, '0);
    exp_rd = 0;
    exp_wr = 0;
    check_counts("t4_rst");
    @(negedge clk);
    rst = 1'b0;
    gnt_seen = 0;
    repeat (LAT + 10) begin
      @(negedge clk);
      if (gnt) gnt_seen++;
    end
    check("t4_no_gnt", 256'(gnt_seen), 256'(0));
    debug_addr = 32'hC0;
    @(negedge clk);
    check("t4_debug_c0", 256'(debug_out_data), 256'(0));
    check_counts("t4");

    // ---- Word 3 of line 0x100 and the debug port ------------------------------
    addr               = 32'h100;
    wr_line            = '0;
    wr_line[96 +: 32]  = 32'h1234_5678;
    wr_req             = 1'b1;
    debug_addr         = 32'h10C;
    wait_gnt(0, cyc);
    check("t5_wr_latency",     256'(cyc), 256'(LAT));
    check("t5_debug_uncommit", 256'(debug_out_data), 256'(0));
    wr_req = 1'b0;
    exp_wr++;
    repeat (2) @(negedge clk);
    check("t5_debug_word3", 256'(debug_out_data), 256'(32'h1234_5678));
    debug_addr = 32'h108;
    @(negedge clk);
    check("t5_debug_word2", 256'(debug_out_data), 256'(0));
    check_counts("t5");

    // ---- Aliasing: 0x0 and 0x1000 map to the same line -------------------------
    addr    = 32'h0;
    wr_line = make_line(32'h1000_0000);
    wr_req  = 1'b1;
    wait_gnt(0, cyc);
    check("t6_wr_latency", 256'(cyc), 256'(LAT));
    wr_req = 1'b0;
    rd_req = 1'b1;
    addr   = 32'h1000;
    exp_wr++;
    wait_gnt(0, cyc);
    check("t6_gnt_gap",  256'(cyc), 256'(LAT + 1));
    check("t6_rd_alias", rd_line, make_line(32'h1000_0000));
    rd_req     = 1'b0;
    debug_addr = 32'h1014;
    exp_rd++;
    @(negedge clk);
    check_counts("t6");
    @(negedge clk);
    check("t6_debug_alias", 256'(debug_out_data), 256'(32'h1000_0005));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
